ram_port_ctrl: RTL
==================

// Module: ram_port_ctrl
// PURPOSE
//  Upstream request front-end for the 256x8 single-port synchronous RAM. Accepts valid/ready
//  read/write requests from a host and drives the RAM's address/data_in/write_enable from
//  registers. Returns read data through a backpressured response channel.
//  Optional clear engine fills the whole RAM with a constant value.
// PARAMETERS
//  AW          8      address width; DEPTH = 2**AW words
//  DW          8      data width
//  FILL_VALUE  8'h00  word written by clear engine (DW bits)
// PORTS
//  clk            in   1   rising-edge clock
//  rst_n          in   1   async active-low reset
//  req_valid      in   1   host request valid
//  req_ready      out  1   request accepted when valid&&ready at clk edge
//  req_write      in   1   1=write, 0=read
//  req_addr       in   AW  request address
//  req_wdata      in   DW  write data
//  resp_valid     out  1   read response valid
//  resp_ready     in   1   host accepts response
//  resp_rdata     out  DW  read data
//  clr_start      in   1   pulse: start clear (clear engine only)
//  busy           out  1   clear in progress
//  clr_done       out  1   1-cycle pulse after last clear write issued
//  address        out  AW  to RAM address (registered)
//  data_in        out  DW  to RAM data_in (registered)
//  write_enable   out  1   to RAM write_enable (registered)
//  data_out       in   DW  from RAM registered read data
// BEHAVIOUR
//  - Reset (async, rst_n=0): address/data_in=0, write_enable=0, resp_valid=0, busy=0,
//    clr_done=0, state=IDLE, response buffer empty, outstanding count=0. RAM contents untouched.
//  - Issue: on accept at edge N, address/data_in/write_enable(=req_write) register at N.
//    RAM samples at N+1. Cycles with no accept drive write_enable=0; address holds.
//  - Read latency: RAM data_out valid after edge N+1. Data enters 2-entry response FIFO at edge N+2.
//    resp_valid is first high in the cycle after N+2 (min 3 cycles accept->resp_valid).
//  - Writes produce no response. Back-to-back write(A) then read(A) returns new data.
//  - Response FIFO: 2 entries, in-order; pop on resp_valid&&resp_ready. Push and pop in the
//    same cycle are both honoured.
//  - Credit: outstanding = reads in pipeline + FIFO occupancy, max 2.
//    req_ready=0 when a read accept would exceed 2 (after counting this cycle's pop).
//    Writes are accepted regardless of credit. A response is never dropped.
//  - req_ready = (state==IDLE) && credit_ok && !clr_start. Combinational from clr_start and
//    resp_ready; no combinational path from req_valid.
//  - FSM (clear engine): IDLE --clr_start--> CLEAR (cnt=0, busy=1).
//    CLEAR: drive address=cnt, data_in=FILL_VALUE, write_enable=1 each cycle, cnt++.
//    After address DEPTH-1 is issued, return to IDLE: busy=0, clr_done=1 for one cycle.
//    Total DEPTH cycles. clr_start in CLEAR is ignored.
//  - Simultaneous clr_start && req_valid in IDLE: clear wins; request not accepted.
//  - Reads accepted before clear complete normally; responses drain during CLEAR.
//  - Reset mid-clear aborts immediately; RAM is left partially filled; no clr_done.
//  - cnt is AW+1 bits; no wrap of the address during clear.
// CONFIGURATION
//  RAM_PORT_CTRL_CLEAR_EN defined: clear engine and FSM present as above.
//  Not defined: no FSM; clr_start ignored; busy=0 and clr_done=0 constantly;
//  req_ready = credit_ok.
// TESTING
//  1 Reset: hold rst_n=0 mid-stream -> all outputs 0 immediately; write_enable=0;
//    req_ready=1 after release.
//  2 Write 0x3C to addr 0x10, then read 0x10 next cycle -> resp_rdata=0x3C,
//    resp_valid 3 cycles after read accept.
//  3 Backpressure: resp_ready=0, issue 4 reads -> 2 accepted, req_ready=0;
//    release resp_ready -> 4 responses in order, none lost/duplicated.
//  4 Clear (CLEAR_EN, FILL_VALUE=0xA5): clr_start -> busy for 256 cycles,
//    write_enable high on addresses 0x00..0xFF, clr_done single pulse; read 0x7F -> 0xA5.
//  5 clr_start with req_valid same cycle -> request not accepted; accepted after clr_done.
//    Pulse rst_n at cycle 100 of clear -> busy=0, no clr_done, addr 0x63 written, 0x64 not.
//  6 Without CLEAR_EN: pulse clr_start -> busy/clr_done stay 0; traffic of tests 2-3 unaffected.

Source files
------------

// File: rtl/ram_port_ctrl.sv
// ram_port_ctrl: request front-end for a 2**AW x DW single-port synchronous RAM.
//
// Host side takes valid/ready read/write requests. Read data comes back through a 2-entry
// response FIFO with valid/ready backpressure. RAM side: address, data_in and write_enable
// are registered outputs, and data_out is the RAM's registered read data.
//
// Optional clear engine (define RAM_PORT_CTRL_CLEAR_EN): clr_start fills every word with
// FILL_VALUE, one word per cycle. busy is high while the fill runs. clr_done pulses once
// when the fill completes. With the macro undefined, clr_start is ignored and busy/clr_done
// are tied to 0.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   req_valid/req_ready              request handshake
//   req_write/req_addr/req_wdata     request payload
//   resp_valid/resp_ready/resp_rdata read response channel
//   clr_start, busy, clr_done        clear engine control/status
//   address, data_in, write_enable   registered RAM controls
//   data_out                         RAM registered read data
module ram_port_ctrl #(
  parameter int unsigned    AW         = 8,
  parameter int unsigned    DW         = 8,
  parameter logic [DW-1:0]  FILL_VALUE = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_rdata,
  input  logic          clr_start,
  output logic          busy,
  output logic          clr_done,
  output logic [AW-1:0] address,
  output logic [DW-1:0] data_in,
  output logic          write_enable,
  input  logic [DW-1:0] data_out
);

  // Read tracking: rd_p1_q marks a read address on the bus and rd_p2_q marks valid data_out.
  logic          rd_p1_q, rd_p2_q;
  logic [DW-1:0] fifo_q [2];
  logic          wptr_q, rptr_q;
  logic [1:0]    count_q;

  logic          push, pop, accept, credit_ok;
  logic [2:0]    outstanding, out_after_pop;

  assign push       = rd_p2_q;
  assign resp_valid = (count_q != 2'd0);
  assign resp_rdata = fifo_q[rptr_q];
  assign pop        = resp_valid && resp_ready;

  // Reads in flight plus buffered responses. This count never exceeds the FIFO depth,
  // so a response always has a slot when its data arrives.
  assign outstanding   = {2'b0, rd_p1_q} + {2'b0, rd_p2_q} + {1'b0, count_q};
  assign out_after_pop = outstanding - {2'b0, pop};
  assign credit_ok     = req_write || (out_after_pop < 3'd2);
  assign accept        = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_p1_q   <= 1'b0;
      rd_p2_q   <= 1'b0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wptr_q    <= 1'b0;
      rptr_q    <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      rd_p1_q <= accept && !req_write;
      rd_p2_q <= rd_p1_q;
      if (push) begin
        fifo_q[wptr_q] <= data_out;
        wptr_q         <= ~wptr_q;
      end
      if (pop) begin
        rptr_q <= ~rptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef RAM_PORT_CTRL_CLEAR_EN

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  localparam logic [AW:0] CntEnd = {1'b1, {AW{1'b0}}};

  state_e      state_q;
  // Next clear address to issue; one bit wider than the address so it reaches DEPTH
  // without wrapping.
  logic [AW:0] cnt_q;

  assign req_ready = (state_q == StIdle) && credit_ok && !clr_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      busy         <= 1'b0;
      clr_done     <= 1'b0;
      address      <= '0;
      data_in      <= '0;
      write_enable <= 1'b0;
    end else begin
      clr_done     <= 1'b0;
      write_enable <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (clr_start) begin
            // Issue address 0 on entry so the fill takes exactly DEPTH busy cycles.
            state_q      <= StClear;
            busy         <= 1'b1;
            address      <= '0;
            data_in      <= FILL_VALUE;
            write_enable <= 1'b1;
            cnt_q        <= {{AW{1'b0}}, 1'b1};
          end else if (accept) begin
            address      <= req_addr;
            data_in      <= req_wdata;
            write_enable <= req_write;
          end
        end
        StClear: begin
          if (cnt_q == CntEnd) begin
            state_q  <= StIdle;
            busy     <= 1'b0;
            clr_done <= 1'b1;
            cnt_q    <= '0;
          end else begin
            address      <= cnt_q[AW-1:0];
            data_in      <= FILL_VALUE;
            write_enable <= 1'b1;
            cnt_q        <= cnt_q + {{AW{1'b0}}, 1'b1};
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`else

  logic unused_clr_start;
  assign unused_clr_start = clr_start;

  assign req_ready = credit_ok;
  assign busy      = 1'b0;
  assign clr_done  = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      address      <= '0;
      data_in      <= '0;
      write_enable <= 1'b0;
    end else begin
      write_enable <= 1'b0;
      if (accept) begin
        address      <= req_addr;
        data_in      <= req_wdata;
        write_enable <= req_write;
      end
    end
  end

`endif

endmodule
